// File: rtl/fetch_unit_pkg.sv
// Shared constants and helpers for the fetch unit: instruction width, PC step,
// fetch-buffer entry layout and saturating counter increment.
package fetch_unit_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_INC  = 4;

  // Buffer entry layout, LSB first: instr, pred_target, pred_taken, pc
  function automatic int entry_w(input int addr_w);
    return (2 * addr_w) + 1 + INSTR_W;
  endfunction

  function automatic int off_target();
    return INSTR_W;
  endfunction

  function automatic int off_taken(input int addr_w);
    return INSTR_W + addr_w;
  endfunction

  function automatic int off_pc(input int addr_w);
    return INSTR_W + addr_w + 1;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle of the fetch unit: instruction memory, branch predictor,
// execute redirect and decode handshake. master = fetch unit side.
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 32
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [ADDR_W-1:0]  pred_pc;
  logic               pred_taken;
  logic [ADDR_W-1:0]  pred_target;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               dec_valid;
  logic               dec_ready;
  logic [ADDR_W-1:0]  dec_pc;
  logic [INSTR_W-1:0] dec_instr;
  logic               dec_pred_taken;
  logic [ADDR_W-1:0]  dec_pred_target;

  modport master (
    output imem_req, imem_addr, pred_pc, dec_valid, dec_pc, dec_instr,
           dec_pred_taken, dec_pred_target,
    input  imem_rdata, pred_taken, pred_target, redirect_valid, redirect_pc,
           dec_ready
  );

  modport slave (
    input  imem_req, imem_addr, pred_pc, dec_valid, dec_pc, dec_instr,
           dec_pred_taken, dec_pred_target,
    output imem_rdata, pred_taken, pred_target, redirect_valid, redirect_pc,
           dec_ready
  );
endinterface

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO (DEPTH a power of 2) holding
// tag+instruction entries; flush takes priority over push and pop.
module fetch_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [DATA_W-1:0]       wdata,
  output logic [DATA_W-1:0]       rdata,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0]  mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W:0]     count_r;

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + {{PTR_W{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{PTR_W{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC, issue/epoch tracking and decode hand-off via fetch_fifo.
// Optional perf counters enabled by `FETCH_PERF_CNT_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = {ADDR_W{1'b0}},
  parameter int                BUF_DEPTH = 2
) (
  input  logic          sysclk,
  input  logic          nrst,
  fetch_unit_if.master  bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   perf_redirects,
  output logic [31:0]   perf_stall_cycles
`endif
);
  localparam int CNT_W   = $clog2(BUF_DEPTH) + 1;
  localparam int ENT_W   = entry_w(ADDR_W);
  localparam int OFF_TGT = off_target();
  localparam int OFF_TKN = off_taken(ADDR_W);
  localparam int OFF_PC  = off_pc(ADDR_W);
  localparam logic [CNT_W:0]  DEPTH_V = (CNT_W+1)'(BUF_DEPTH);
  localparam logic [ADDR_W-1:0] INC_V = ADDR_W'(PC_INC);

  logic [ADDR_W-1:0] fetch_pc_r;
  logic              inflight_r;
  logic [ADDR_W-1:0] infl_pc_r;
  logic              infl_taken_r;
  logic [ADDR_W-1:0] infl_target_r;
  logic              infl_epoch_r;
  logic              epoch_r;

  logic [CNT_W-1:0]  count_s;
  logic [CNT_W:0]    occ_s;
  logic              dec_valid_s;
  logic              pop_s;
  logic              issue_s;
  logic              push_s;
  logic [ENT_W-1:0]  wdata_s;
  logic [ENT_W-1:0]  rdata_s;

  // Issue only when the slot for the response is guaranteed free after this cycle's pop
  always_comb begin
    dec_valid_s = (count_s != '0) && !bus.redirect_valid;
    pop_s       = dec_valid_s && bus.dec_ready;
    occ_s       = {1'b0, count_s} + {{CNT_W{1'b0}}, inflight_r}
                - {{CNT_W{1'b0}}, pop_s};
    issue_s     = nrst && !bus.redirect_valid && (occ_s < DEPTH_V);
    push_s      = inflight_r && (infl_epoch_r == epoch_r);
    wdata_s     = {infl_pc_r, infl_taken_r, infl_target_r, bus.imem_rdata};
  end

  assign bus.imem_req        = issue_s;
  assign bus.imem_addr       = fetch_pc_r;
  assign bus.pred_pc         = fetch_pc_r;
  assign bus.dec_valid       = dec_valid_s;
  assign bus.dec_instr       = rdata_s[INSTR_W-1:0];
  assign bus.dec_pred_target = rdata_s[OFF_TGT +: ADDR_W];
  assign bus.dec_pred_taken  = rdata_s[OFF_TKN];
  assign bus.dec_pc          = rdata_s[OFF_PC +: ADDR_W];

  // Fetch PC, in-flight tag and epoch; a redirect overrides everything else
  always_ff @(posedge sysclk or negedge nrst) begin
    if (!nrst) begin
      fetch_pc_r    <= RESET_PC;
      inflight_r    <= 1'b0;
      infl_pc_r     <= '0;
      infl_taken_r  <= 1'b0;
      infl_target_r <= '0;
      infl_epoch_r  <= 1'b0;
      epoch_r       <= 1'b0;
    end else if (bus.redirect_valid) begin
      fetch_pc_r <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
      epoch_r    <= ~epoch_r;
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= issue_s;
      if (issue_s) begin
        fetch_pc_r    <= bus.pred_taken ? bus.pred_target : (fetch_pc_r + INC_V);
        infl_pc_r     <= fetch_pc_r;
        infl_taken_r  <= bus.pred_taken;
        infl_target_r <= bus.pred_target;
        infl_epoch_r  <= epoch_r;
      end
    end
  end

  fetch_fifo #(
    .DEPTH  (BUF_DEPTH),
    .DATA_W (ENT_W)
  ) u_fifo (
    .clk   (sysclk),
    .rst_n (nrst),
    .push  (push_s),
    .pop   (pop_s),
    .flush (bus.redirect_valid),
    .wdata (wdata_s),
    .rdata (rdata_s),
    .count (count_s)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_redirects_r;
  logic [31:0] perf_stall_r;

  assign perf_redirects    = perf_redirects_r;
  assign perf_stall_cycles = perf_stall_r;

  // Saturating event counters for redirects and decode back-pressure
  always_ff @(posedge sysclk or negedge nrst) begin
    if (!nrst) begin
      perf_redirects_r <= 32'd0;
      perf_stall_r     <= 32'd0;
    end else begin
      if (bus.redirect_valid) begin
        perf_redirects_r <= sat_inc(perf_redirects_r);
      end
      if (dec_valid_s && !bus.dec_ready) begin
        perf_stall_r <= sat_inc(perf_stall_r);
      end
    end
  end
`endif

endmodule
